store_merge_unit: RTL and testbench

Memory-stage store path for the five-stage pipeline: the write-side counterpart of the writeback load extractor (lb/lbu lane select). Implements sw, sh and sb against the word-wide, single-port, synchronous-read data memory, which has no byte enables. sw writes in one cycle. sh and sb use a two-cycle read-modify-write sequence, and the block stalls the pipeline for one cycle while it runs. The block owns the data-memory port; when idle it presents the load address so that loads are unaffected.

---
 rtl/mips_pkg.sv | 16 +
 rtl/lane_merge.sv | 30 +++
 rtl/store_merge_unit.sv | 114 +++++++++++
 tb/tb_store_merge_unit.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared pipeline definitions: memory opcodes used by the load and store paths
// and the state encoding of the store read-modify-write sequencer.
package mips_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } state_e;

endpackage

// File: rtl/lane_merge.sv
// Replaces one little-endian byte or halfword lane of a word with new data,
// leaving every other lane as it was in the old word.
module lane_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [1:0]  offset,
    input  logic        is_half,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_word;
        if (is_half) begin
            // Only offsets 00 and 10 reach here; bit 0 is ignored.
            if (offset[1]) begin
                merged[31:16] = new_data[15:0];
            end else begin
                merged[15:0] = new_data[15:0];
            end
        end else begin
            case (offset)
                2'b00:   merged[7:0]   = new_data[7:0];
                2'b01:   merged[15:8]  = new_data[7:0];
                2'b10:   merged[23:16] = new_data[7:0];
                default: merged[31:24] = new_data[7:0];
            endcase
        end
    end

endmodule

// File: rtl/store_merge_unit.sv
// Mem-stage store path: sw writes directly, sh/sb do a read-modify-write over
// two cycles on a word-wide RAM without byte enables, stalling the pipe once.
module store_merge_unit #(
    parameter logic [5:0] OP_SW = mips_pkg::OP_SW,
    parameter logic [5:0] OP_SH = mips_pkg::OP_SH,
    parameter logic [5:0] OP_SB = mips_pkg::OP_SB
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  Mem_op,
    input  logic        Mem_MemWr,
    input  logic [31:0] Mem_alure,
    input  logic [31:0] Mem_busB,
    input  logic [31:0] mem_rdata,
    output logic [29:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    output logic        stall,
    output logic        misalign
);

    import mips_pkg::*;

    state_e      state_q, state_d;
    logic [29:0] addr_q, addr_d;
    logic [1:0]  off_q, off_d;
    logic        half_q, half_d;
    logic [31:0] data_q, data_d;

    logic        req_sw, req_sh, req_sb;
    logic [1:0]  req_off;
    logic [31:0] merged_word;

    assign req_off = Mem_alure[1:0];
    assign req_sw  = Mem_MemWr && (Mem_op == OP_SW);
    assign req_sh  = Mem_MemWr && (Mem_op == OP_SH);
    assign req_sb  = Mem_MemWr && (Mem_op == OP_SB);

    lane_merge u_lane_merge (
        .old_word (mem_rdata),
        .new_data (data_q),
        .offset   (off_q),
        .is_half  (half_q),
        .merged   (merged_word)
    );

    // Outputs are gated by rst_n so that reset silences the RAM port at once,
    // even when it lands in the middle of a MERGE cycle.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        off_d     = off_q;
        half_d    = half_q;
        data_d    = data_q;
        mem_addr  = Mem_alure[31:2];
        mem_we    = 1'b0;
        mem_wdata = Mem_busB;
        stall     = 1'b0;
        misalign  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_sw) begin
                    if (req_off == 2'b00) begin
                        mem_we = 1'b1;
                    end else begin
                        misalign = 1'b1;
                    end
                end else if (req_sb || (req_sh && !req_off[0])) begin
                    stall   = 1'b1;
                    addr_d  = Mem_alure[31:2];
                    off_d   = req_off;
                    half_d  = req_sh;
                    data_d  = Mem_busB;
                    state_d = MERGE;
                end else if (req_sh) begin
                    misalign = 1'b1;
                end
            end
            MERGE: begin
                mem_addr  = addr_q;
                mem_wdata = merged_word;
                mem_we    = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (!rst_n) begin
            mem_addr  = '0;
            mem_we    = 1'b0;
            mem_wdata = '0;
            stall     = 1'b0;
            misalign  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            off_q   <= '0;
            half_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            off_q   <= off_d;
            half_q  <= half_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_store_merge_unit.sv
// Randomized self-checking bench for store_merge_unit: a small word RAM sits on
// the port and a lane-mask reference memory predicts every store's effect.
module tb_store_merge_unit;

    localparam logic [5:0] SW = 6'b101011;
    localparam logic [5:0] SH = 6'b101001;
    localparam logic [5:0] SB = 6'b101000;
    localparam logic [5:0] LW = 6'b100011;

    logic        clk;
    logic        rst_n;
    logic [5:0]  Mem_op;
    logic        Mem_MemWr;
    logic [31:0] Mem_alure;
    logic [31:0] Mem_busB;
    logic [31:0] mem_rdata;
    logic [29:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        stall;
    logic        misalign;

    logic [31:0] ram     [0:15];
    logic [31:0] ref_mem [0:15];

    int nChecks = 0;
    int nFails  = 0;

    store_merge_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Mem_op    (Mem_op),
        .Mem_MemWr (Mem_MemWr),
        .Mem_alure (Mem_alure),
        .Mem_busB  (Mem_busB),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .stall     (stall),
        .misalign  (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read, word-wide RAM with no byte enables.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[3:0]] <= mem_wdata;
        mem_rdata <= ram[mem_addr[3:0]];
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] refMerge(input logic [31:0] old, input logic [31:0] data,
                                             input logic [1:0] off, input logic half);
        logic [31:0] mask;
        mask = (half ? 32'h0000_FFFF : 32'h0000_00FF) << (8 * off);
        return (old & ~mask) | ((data << (8 * off)) & mask);
    endfunction

    // Presents one Mem-stage instruction (held while stalled) and checks every cycle.
    task automatic applyStimulus(input logic [5:0] op, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] data);
        logic [3:0]  idx;
        logic [1:0]  off;
        logic        expSw, expRmw, expMis;
        logic [31:0] expWord;
        idx    = addr[5:2];
        off    = addr[1:0];
        expSw  = wr && op == SW && off == 2'b00;
        expRmw = wr && (op == SB || (op == SH && !off[0]));
        expMis = wr && ((op == SW && off != 2'b00) || (op == SH && off[0]));
        expWord = refMerge(ref_mem[idx], data, off, op == SH);

        Mem_op = op; Mem_MemWr = wr; Mem_alure = addr; Mem_busB = data;
        @(negedge clk);
        checkOutput("c0_addr",  {2'b00, mem_addr}, {2'b00, addr[31:2]});
        checkOutput("c0_we",    {31'd0, mem_we},   {31'd0, expSw});
        checkOutput("c0_stall", {31'd0, stall},    {31'd0, expRmw});
        checkOutput("c0_mis",   {31'd0, misalign}, {31'd0, expMis});
        if (expSw) checkOutput("sw_wdata", mem_wdata, data);
        @(posedge clk); #1;
        if (expSw) ref_mem[idx] = data;
        if (!expSw && !expRmw) checkOutput("load_rdata", mem_rdata, ref_mem[idx]);
        if (expRmw) begin
            @(negedge clk);
            checkOutput("c1_addr",  {2'b00, mem_addr}, {2'b00, addr[31:2]});
            checkOutput("c1_we",    {31'd0, mem_we},   32'd1);
            checkOutput("c1_stall", {31'd0, stall},    32'd0);
            checkOutput("c1_wdata", mem_wdata, expWord);
            @(posedge clk); #1;
            ref_mem[idx] = expWord;
        end
    endtask

    task automatic checkRam(input string tag);
        for (int i = 0; i < 16; i++) checkOutput(tag, ram[i], ref_mem[i]);
    endtask

    initial begin
        logic [5:0]  ops [0:5];
        logic [31:0] sbExp [0:3];
        ops[0] = SW; ops[1] = SH; ops[2] = SB; ops[3] = SB; ops[4] = LW; ops[5] = 6'b000000;
        sbExp[0] = 32'h1122_33AA; sbExp[1] = 32'h1122_AA44;
        sbExp[2] = 32'h11AA_3344; sbExp[3] = 32'hAA22_3344;
        for (int i = 0; i < 16; i++) begin
            ram[i]     = 32'h5A00_0000 + i;
            ref_mem[i] = 32'h5A00_0000 + i;
        end

        // Reset held with an sw requested: the port must stay silent.
        rst_n = 1'b0;
        Mem_op = SW; Mem_MemWr = 1'b1; Mem_alure = 32'h0000_0010; Mem_busB = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        checkOutput("rst_we",    {31'd0, mem_we},   32'd0);
        checkOutput("rst_stall", {31'd0, stall},    32'd0);
        checkOutput("rst_mis",   {31'd0, misalign}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(SW, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        applyStimulus(LW, 1'b0, 32'h0000_0010, 32'h0);

        // sb at each offset into 0x11223344.
        for (int o = 0; o < 4; o++) begin
            applyStimulus(SW, 1'b1, 32'h0000_0010, 32'h1122_3344);
            applyStimulus(SB, 1'b1, 32'h0000_0010 + o, 32'h0000_00AA);
            checkOutput("sb_word", ref_mem[4], sbExp[o]);
            applyStimulus(LW, 1'b0, 32'h0000_0010, 32'h0);
        end

        applyStimulus(SW, 1'b1, 32'h0000_0014, 32'h1122_3344);
        applyStimulus(SH, 1'b1, 32'h0000_0016, 32'h0000_BEEF);
        applyStimulus(LW, 1'b0, 32'h0000_0014, 32'h0);
        checkOutput("sh_word", ram[5], 32'hBEEF_3344);

        applyStimulus(SH, 1'b1, 32'h0000_0015, 32'h0000_1234);
        applyStimulus(SW, 1'b1, 32'h0000_0016, 32'h0BAD_0BAD);
        applyStimulus(6'b111111, 1'b1, 32'h0000_0014, 32'hFFFF_FFFF);
        applyStimulus(SW, 1'b0, 32'h0000_0014, 32'hFFFF_FFFF);
        checkOutput("mis_word", ram[5], 32'hBEEF_3344);

        // Reset lands in MERGE of an sb: the write must be abandoned.
        applyStimulus(SW, 1'b1, 32'h0000_0020, 32'h1122_3344);
        Mem_op = SB; Mem_MemWr = 1'b1; Mem_alure = 32'h0000_0021; Mem_busB = 32'h0000_00CC;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rstm_we",    {31'd0, mem_we}, 32'd0);
        checkOutput("rstm_stall", {31'd0, stall},  32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        Mem_MemWr = 1'b0;
        @(posedge clk); #1;
        checkOutput("rstm_word", ram[8], 32'h1122_3344);
        applyStimulus(SW, 1'b1, 32'h0000_0020, 32'h7777_8888);
        checkOutput("post_rst_sw", ram[8], 32'h7777_8888);

        // Random mix, including back-to-back stores and loads after RMW.
        for (int n = 0; n < 300; n++) begin
            applyStimulus(ops[$urandom_range(0, 5)], 1'($urandom_range(0, 3) != 0),
                          {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))},
                          $urandom);
        end
        applyStimulus(LW, 1'b0, 32'h0, 32'h0);
        checkRam("ram_final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFails);
        $finish;
    end

endmodule
